// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and constants for the UART transmit path.
// Frame state encoding and default line settings.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DATA_BITS   = 8;
  localparam int DEFAULT_BAUD     = 9600;
  localparam int DEFAULT_CLK_FREQ = 100000000;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Request/status bundle between the button path and the UART transmitter.
// The master presents transmit/data; the slave returns the line and status.
interface uart_tx_if;
  import uart_pkg::*;

  logic                      transmit;
  logic [UART_DATA_BITS-1:0] data;
  logic                      txd;
  logic                      busy;
  logic                      done;

  modport master (
    output transmit,
    output data,
    input  txd,
    input  busy,
    input  done
  );

  modport slave (
    input  transmit,
    input  data,
    output txd,
    output busy,
    output done
  );

endinterface

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
// Bit-period counter: tick marks the last cycle of each bit period.
// clear restarts the period, e.g. whenever the frame FSM changes state.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  // count up to the terminal value, then restart at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: one 8N1 frame per rising edge of transmit.
// Edges seen while a frame is in flight are dropped, not queued.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int BAUD     = DEFAULT_BAUD
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(UART_DATA_BITS - 1);

  uart_state_t               state;
  uart_state_t               state_n;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] shift_n;
  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          idx_n;
  logic                      transmit_d;
  logic                      start_req;
  logic                      tick;
  logic                      clear;
  logic                      done_n;
  logic                      done_q;
  logic                      txd_c;
  logic                      busy_c;

  assign start_req = bus.transmit & ~transmit_d;
  assign clear     = (state == IDLE) | (state_n != state);

  assign bus.txd  = txd_c;
  assign bus.busy = busy_c;
  assign bus.done = done_q;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(clear),
    .tick (tick)
  );

  // frame state, payload, and edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift      <= '0;
      idx        <= '0;
      transmit_d <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      idx        <= idx_n;
      transmit_d <= bus.transmit;
      done_q     <= done_n;
    end
  end

  // next-state, payload update and line drive
  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    done_n  = 1'b0;
    txd_c   = 1'b1;
    busy_c  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_req) begin
          shift_n = bus.data;
          state_n = START;
        end
      end
      START: begin
        txd_c  = 1'b0;
        busy_c = 1'b1;
        if (tick) begin
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        txd_c  = shift[0];
        busy_c = 1'b1;
        if (tick) begin
          shift_n = shift >> 1;
          idx_n   = idx + 1'b1;
          if (idx == LAST_IDX) begin
            state_n = STOP;
          end
        end
      end
      STOP: begin
        busy_c = 1'b1;
        if (tick) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer at 10 clocks per bit.
// Reference model works on whole frames and bit periods.
module tb_uart_tx_serializer;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst_n;

  uart_tx_if bus();

  uart_tx_serializer #(
    .CLK_FREQ(1000),
    .BAUD    (100)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;

  bit         m_prev;
  bit         m_active;
  bit         m_done;
  int         m_cnt;
  logic [7:0] m_byte;
  logic [7:0] rx_byte;
  int         m_ndone;
  int         d_ndone;

  function automatic logic exp_bit(logic [7:0] b, int k);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    return f[k];
  endfunction

  task automatic check(string tag, logic obs, logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check8(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checki(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit t, input logic [7:0] d);
    int k;
    bus.transmit = t;
    bus.data     = d;
    @(posedge clk);
    m_done = 1'b0;
    if (m_active) begin
      m_cnt++;
      if (m_cnt == FRAME) begin
        m_active = 1'b0;
        m_done   = 1'b1;
        m_ndone++;
      end
    end else if (t && !m_prev) begin
      m_active = 1'b1;
      m_cnt    = 0;
      m_byte   = d;
    end
    m_prev = t;
    #1;
    check("txd", bus.txd,
          m_active ? exp_bit(m_byte, m_cnt / CPB) : 1'b1);
    check("busy", bus.busy, m_active);
    check("done", bus.done, m_done);
    if (bus.done === 1'b1) d_ndone++;
    k = m_cnt / CPB;
    if (m_active && (m_cnt % CPB == CPB / 2) && k >= 1 && k <= 8)
      rx_byte[k-1] = bus.txd;
    if (m_done) check8("payload", rx_byte, m_byte);
    @(negedge clk);
  endtask

  task automatic run(int n, bit t, logic [7:0] d);
    for (int i = 0; i < n; i++) cyc(t, d);
  endtask

  task automatic run_rnd(int n, bit t);
    for (int i = 0; i < n; i++) cyc(t, 8'($urandom));
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_txd", bus.txd, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    m_active = 1'b0;
    m_prev   = 1'b0;
    m_done   = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    m_prev = 0; m_active = 0; m_done = 0; m_cnt = 0;
    m_byte = '0; rx_byte = '0; m_ndone = 0; d_ndone = 0;
    bus.transmit = 1'b0;
    bus.data     = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("init_txd", bus.txd, 1'b1);
    check("init_busy", bus.busy, 1'b0);
    check("init_done", bus.done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    run(50, 1'b0, 8'h00);

    run(200, 1'b1, 8'h55);
    checki("done_cnt_55", d_ndone, 1);
    run(10, 1'b0, 8'h55);

    cyc(1'b1, 8'hA3);
    run(38, 1'b0, 8'hA3);
    cyc(1'b1, 8'h3A);
    run_rnd(130, 1'b0);
    checki("done_cnt_a3", d_ndone, 2);

    run(25, 1'b1, 8'h0F);
    run(150, 1'b1, 8'hFF);
    run(10, 1'b0, 8'hFF);
    checki("done_cnt_0f", d_ndone, 3);

    run_rnd(55, 1'b1);
    do_reset();
    run_rnd(120, 1'b1);
    run_rnd(10, 1'b0);
    run_rnd(120, 1'b1);
    run_rnd(10, 1'b0);
    checki("done_cnt_rst", d_ndone, 5);

    cyc(1'b1, 8'h00);
    run(149, 1'b0, 8'h00);
    cyc(1'b1, 8'hFF);
    run(149, 1'b0, 8'hFF);
    checki("done_cnt_pair", d_ndone, 7);

    for (int r = 0; r < 25; r++) begin
      run_rnd(int'($urandom_range(1, 140)), 1'b1);
      run_rnd(int'($urandom_range(1, 140)), 1'b0);
      if ($urandom_range(0, 7) == 0) do_reset();
    end
    run_rnd(FRAME + 5, 1'b0);
    checki("done_cnt_total", d_ndone, m_ndone);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Sits directly downstream of the push-button debouncer.
- Consumes the debounced `transmit` level and, on each new press, serialises one 8-bit value as a UART frame: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Drives the board TX pin toward the host PC and reports busy/done status to the design.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division; 10416 at defaults), clock cycles per bit. Derived; not overridden directly.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- transmit  input  1  debounced level; one frame per rising edge.
- data  input  8  byte to send; sampled only on the accepted edge.
- txd  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at the end of the stop bit.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, txd = 1, busy = 0, done = 0.
  - baud counter = 0, bit index = 0, shift register = 0, transmit_d = 0.
- Edge detect:
  - transmit_d <= transmit every cycle, in all states.
  - start_req = transmit & ~transmit_d.
  - transmit is already synchronised upstream; no extra synchroniser.
- IDLE:
  - txd = 1, busy = 0.
  - On start_req: latch data into the shift register, go to START.
  - txd falls on the clock edge after the cycle in which transmit is first sampled high.
- START:
  - txd = 0, busy = 1.
  - Hold for CLKS_PER_BIT cycles, then go to DATA with bit index = 0.
- DATA:
  - txd = shift[0].
  - After CLKS_PER_BIT cycles, shift right by 1 and increment the bit index.
  - After bit 7 completes, go to STOP.
- STOP:
  - txd = 1.
  - After CLKS_PER_BIT cycles, go to IDLE and pulse done = 1 for exactly that one cycle.
  - busy deasserts in the same cycle.
- Frame length:
  - Exactly 10*CLKS_PER_BIT cycles from the first txd=0 cycle to the return to IDLE.
- Baud counter:
  - Width = clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and clears to 0 on each bit boundary and on every state change.
  - Never wraps past the terminal value.
- Rising edge while busy:
  - Ignored and not queued. transmit_d still tracks transmit, so no deferred frame is sent.
- transmit held high past the end of a frame:
  - No retransmission. A release followed by a new press is required.
- data changes mid-frame:
  - No effect; only the latched copy is sent.
- Reset mid-frame:
  - txd returns to 1 immediately (asynchronously). The partial frame is abandoned and done does not pulse.
- After reset release with transmit already high:
  - One frame is sent, because transmit_d resets to 0. This is intended: a press held through reset counts as a press.

Decomposition:
- Shared package `uart_pkg`:
  - state enum IDLE/START/DATA/STOP (2 bits).
  - UART_DATA_BITS = 8.
  - Default baud constant.
- One natural sub-module, `baud_tick_gen`:
  - Counter parameterised by CLKS_PER_BIT.
  - Inputs clk, rst_n, clear; output tick at the terminal count.
  - The FSM, edge detect and shift register stay in the top module.

Test Plan:
Bench parameters: CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10.
- Reset then idle, transmit=0 for 50 cycles -> txd=1, busy=0, done=0 throughout.
- data=8'h55, transmit 0->1 held 200 cycles:
  - txd pattern 0,1,0,1,0,1,0,1,0,1, each bit exactly 10 cycles, first low one cycle after transmit is sampled.
  - busy high for 100 cycles; done pulses once at cycle 100.
  - No second frame while transmit stays high.
- data=8'hA3, press; second 0->1 pulse on transmit at cycle 40 of the frame -> only bits 1,1,0,0,0,1,0,1 are sent, and txd stays 1 after done.
- data=8'h0F, press, change data to 8'hFF at cycle 25 -> the serial payload decodes as 8'h0F.
- Assert rst_n=0 at cycle 55 of a frame -> txd=1 and busy=0 within the same cycle, no done pulse; the next press sends a full clean frame.
- Two presses spaced 150 cycles apart with data 8'h00 then 8'hFF -> two complete frames, two done pulses, line idle high between them.
